// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
//   Shared types for the instruction fetch unit.
//   - IMEM_AW        : program memory word-address width
//   - fetch_state_t  : fetch FSM states
//   - fetch_entry_t  : one prefetched word together with its fetch address
// ---------------------------------------------------------------------------
package ifetch_pkg;

    localparam int IMEM_AW = 16;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_RUN,
        FS_DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [IMEM_AW-1:0] addr;
        logic [IMEM_AW-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Synchronous prefetch FIFO of fetch_entry_t, DEPTH entries (power of 2).
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     push_in           write push_entry_in at the tail
//     push_entry_in     entry to write
//     pop_in            drop the head entry
//     flush_in          empty the FIFO; wins over push/pop in the same cycle
//     count_out         number of stored entries (0..DEPTH)
//     head_out          current head entry (valid when count_out != 0)
//   A pushed entry becomes visible on head_out the cycle after the push.
// ---------------------------------------------------------------------------
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_in,
    input  fetch_entry_t             push_entry_in,
    input  logic                     pop_in,
    input  logic                     flush_in,
    output logic [$clog2(DEPTH):0]   count_out,
    output fetch_entry_t             head_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    fetch_entry_t  entries_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          do_push, do_pop;

    // Guards make the FIFO safe even if a caller misbehaves.
    assign do_pop  = pop_in  && (count_q != '0) && !flush_in;
    assign do_push = push_in && (count_q != DEPTH_W) && !flush_in;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it maps onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (do_push) entries_q[wr_ptr_q] <= push_entry_in;
    end

    assign count_out = count_q;
    assign head_out  = entries_q[rd_ptr_q];

endmodule

// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch
//   Instruction fetch unit. Prefetches program memory into a small FIFO and
//   hands one word per control request to the instruction register.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     en_in                allow memory reads to be issued
//     fetch_req_in         control wants the next instruction (level)
//     redirect_in          1-cycle pulse: flush, restart at redirect_addr_in
//     redirect_addr_in     new fetch word address
//     imem_re_out          memory read request (accepted same cycle)
//     imem_addr_out        memory read address
//     imem_data_in         memory read data
//     imem_valid_in        read data valid, in-order responses
//     ins_out, pc_out      delivered word and its address (registered)
//     il_out               one-cycle IR load strobe (registered)
//     empty_out            prefetch FIFO empty
// ---------------------------------------------------------------------------
module ifetch
    import ifetch_pkg::*;
#(
    parameter int                 DEPTH    = 4,
    parameter int                 MAX_OUT  = 2,
    parameter logic [IMEM_AW-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_in,
    input  logic               fetch_req_in,
    input  logic               redirect_in,
    input  logic [IMEM_AW-1:0] redirect_addr_in,
    output logic               imem_re_out,
    output logic [IMEM_AW-1:0] imem_addr_out,
    input  logic [IMEM_AW-1:0] imem_data_in,
    input  logic               imem_valid_in,
    output logic [IMEM_AW-1:0] ins_out,
    output logic               il_out,
    output logic [IMEM_AW-1:0] pc_out,
    output logic               empty_out
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W   = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] MAX_OUT_W = CW'(MAX_OUT);

    fetch_state_t       state_q, state_d;
    logic [IMEM_AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]      outstanding_q, outstanding_d;
    logic [IMEM_AW-1:0] ins_q, ins_d;
    logic               il_q, il_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;

    logic [CW-1:0]      fifo_count;
    fetch_entry_t       fifo_head;
    fetch_entry_t       push_entry;
    logic [CW:0]        credit_sum;
    logic               issue, resp, push, pop;

    // Credit counts both stored words and reads in flight, so every
    // response always finds a free FIFO slot.
    assign credit_sum = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign issue = (state_q == FS_RUN) && !redirect_in &&
                   (outstanding_q < MAX_OUT_W) && (credit_sum < DEPTH_W);

    // Responses with nothing outstanding are stale (e.g. across a reset).
    assign resp = imem_valid_in && (outstanding_q != '0);
    assign push = resp && (state_q != FS_DRAIN) && !redirect_in;
    assign pop  = fetch_req_in && (fifo_count != '0) && !redirect_in;

    // Kept responses come from consecutive issues ending at fetch_pc
    // (a redirect always drains older reads), so the oldest in-flight
    // read address is fetch_pc minus the number outstanding.
    assign push_entry.addr = fetch_pc_q - IMEM_AW'(outstanding_q);
    assign push_entry.data = imem_data_in;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_in      (push),
        .push_entry_in(push_entry),
        .pop_in       (pop),
        .flush_in     (redirect_in),
        .count_out    (fifo_count),
        .head_out     (fifo_head)
    );

    always_comb begin
        outstanding_d = outstanding_q;
        if (issue && !resp)      outstanding_d = outstanding_q + 1'b1;
        else if (!issue && resp) outstanding_d = outstanding_q - 1'b1;

        fetch_pc_d = fetch_pc_q;
        if (redirect_in) fetch_pc_d = redirect_addr_in;
        else if (issue)  fetch_pc_d = fetch_pc_q + 1'b1;

        state_d = state_q;
        if (redirect_in) begin
            if (outstanding_d != '0) state_d = FS_DRAIN;
            else                     state_d = en_in ? FS_RUN : FS_IDLE;
        end else begin
            case (state_q)
                FS_IDLE:  if (en_in)  state_d = FS_RUN;
                FS_RUN:   if (!en_in) state_d = FS_IDLE;
                FS_DRAIN: if (outstanding_d == '0) state_d = en_in ? FS_RUN : FS_IDLE;
                default:  state_d = FS_IDLE;
            endcase
        end

        il_d  = pop;
        ins_d = pop ? fifo_head.data : ins_q;
        pc_d  = pop ? fifo_head.addr : pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FS_IDLE;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            ins_q         <= '0;
            il_q          <= 1'b0;
            pc_q          <= RESET_PC;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            ins_q         <= ins_d;
            il_q          <= il_d;
            pc_q          <= pc_d;
        end
    end

    assign imem_re_out   = issue;
    assign imem_addr_out = fetch_pc_q;
    assign ins_out       = ins_q;
    assign il_out        = il_q;
    assign pc_out        = pc_q;
    assign empty_out     = (fifo_count == '0);

endmodule
